// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage owning the PC, the ROM interface and the IF/ID register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic [31:0] rom_inst_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] fetch_count_o
);
  logic [31:0] next_pc;
  logic        load;
  logic        bubble;
  logic        unused_bits;
  assign unused_bits = ^{stall[5:3], new_pc[1:0], branch_target_address_i[1:0]};
  // Next PC: flush beats stall, stall beats branch; the first fetch after reset always starts at RESET_PC
  always_comb begin
    next_pc = !rom_ce_o      ? RESET_PC :
              flush          ? {new_pc[31:2], 2'b00} :
              stall[0]       ? rom_addr_o :
              branch_flag_i  ? {branch_target_address_i[31:2], 2'b00} :
                               rom_addr_o + 32'd4;
    bubble  = flush || (stall[1] && !stall[2]);
    load    = !flush && !stall[1];
  end
  // Chip enable lags reset by one edge so the ROM sees a clean RESET_PC before the first read
  always_ff @(posedge clk) begin
    rom_ce_o   <= !rst;
    rom_addr_o <= rst ? RESET_PC : next_pc;
  end
  // IF/ID register: bubbles on flush or when only IF/ID stalls, holds when ID stalls too
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc         <= '0;
      id_inst       <= '0;
      fetch_count_o <= '0;
    end else if (bubble) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (load) begin
      id_pc         <= rom_addr_o;
      id_inst       <= rom_ce_o ? rom_inst_i : '0;
      fetch_count_o <= fetch_count_o + {31'd0, rom_ce_o};
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: vector table, randomized model comparison and mid-run reset for if_fetch_unit
module tb_if_fetch_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic [5:0]  stall = 0;
  logic        flush = 0;
  logic [31:0] new_pc = 0;
  logic        br = 0;
  logic [31:0] tgt = 0;
  logic [31:0] rom_inst;
  logic        rom_ce;
  logic [31:0] rom_addr, id_pc, id_inst, fcnt;
  int checks = 0, errors = 0;

  logic        m_ce;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;

  typedef struct {
    logic r; logic [5:0] s; logic f; logic [31:0] np; logic b; logic [31:0] t;
    logic ce; logic [31:0] addr, ipc, iinst, cnt;
  } vec_t;
  vec_t tbl[22];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_inst = rom(rom_addr);

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(br), .branch_target_address_i(tgt), .rom_inst_i(rom_inst),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .id_pc(id_pc), .id_inst(id_inst),
    .fetch_count_o(fcnt)
  );

  function automatic vec_t v(input logic r, input logic [5:0] s, input logic f, input logic [31:0] np,
                             input logic b, input logic [31:0] t, input logic ce, input logic [31:0] addr,
                             input logic [31:0] ipc, input logic [31:0] iinst, input logic [31:0] cnt);
    vec_t x;
    x.r = r; x.s = s; x.f = f; x.np = np; x.b = b; x.t = t;
    x.ce = ce; x.addr = addr; x.ipc = ipc; x.iinst = iinst; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cmp(input string tag, input logic ce, input logic [31:0] addr,
                     input logic [31:0] ipc, input logic [31:0] iinst, input logic [31:0] cnt);
    chk({tag, " rom_ce"}, {31'd0, rom_ce}, {31'd0, ce});
    chk({tag, " rom_addr"}, rom_addr, addr);
    chk({tag, " id_pc"}, id_pc, ipc);
    chk({tag, " id_inst"}, id_inst, iinst);
    chk({tag, " fetch_count"}, fcnt, cnt);
  endtask

  // Reference model advanced from the spec rules at each edge using the inputs just applied
  task automatic model_edge();
    logic [31:0] npc;
    if (rst) begin
      m_ce = 0; m_pc = 0; m_id_pc = 0; m_id_inst = 0; m_cnt = 0;
    end else begin
      if (!m_ce) npc = 0;
      else if (flush) npc = new_pc & ~32'd3;
      else if (stall[0]) npc = m_pc;
      else if (br) npc = tgt & ~32'd3;
      else npc = m_pc + 4;
      if (flush || (stall[1] && !stall[2])) begin
        m_id_pc = 0; m_id_inst = 0;
      end else if (!stall[1]) begin
        m_id_pc = m_pc;
        m_id_inst = m_ce ? rom(m_pc) : 0;
        if (m_ce) m_cnt = m_cnt + 1;
      end
      m_ce = 1;
      m_pc = npc;
    end
  endtask

  task automatic step(input logic r, input logic [5:0] s, input logic f, input logic [31:0] np,
                      input logic b, input logic [31:0] t);
    rst = r; stall = s; flush = f; new_pc = np; br = b; tgt = t;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    tbl[0]  = v(1, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0);
    tbl[2]  = v(1, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 0, 0, 0, 0,                1, 0, 0, 0, 0);
    tbl[4]  = v(0, 0, 0, 0, 0, 0,                1, 32'h4, 0, 32'h10000000, 1);
    tbl[5]  = v(0, 0, 0, 0, 0, 0,                1, 32'h8, 32'h4, 32'h10000001, 2);
    tbl[6]  = v(0, 0, 0, 0, 1, 32'h40,           1, 32'h40, 32'h8, 32'h10000002, 3);
    tbl[7]  = v(0, 0, 0, 0, 0, 0,                1, 32'h44, 32'h40, 32'h10000010, 4);
    tbl[8]  = v(0, 6'b000011, 0, 0, 0, 0,        1, 32'h44, 0, 0, 4);
    tbl[9]  = v(0, 6'b000011, 0, 0, 0, 0,        1, 32'h44, 0, 0, 4);
    tbl[10] = v(0, 0, 0, 0, 0, 0,                1, 32'h48, 32'h44, 32'h10000011, 5);
    tbl[11] = v(0, 6'b000111, 0, 0, 1, 32'h100,  1, 32'h48, 32'h44, 32'h10000011, 5);
    tbl[12] = v(0, 6'b000111, 0, 0, 1, 32'h100,  1, 32'h48, 32'h44, 32'h10000011, 5);
    tbl[13] = v(0, 0, 0, 0, 1, 32'h100,          1, 32'h100, 32'h48, 32'h10000012, 6);
    tbl[14] = v(0, 6'b000011, 1, 32'h23, 1, 32'h200, 1, 32'h20, 0, 0, 6);
    tbl[15] = v(0, 0, 0, 0, 0, 0,                1, 32'h24, 32'h20, 32'h10000008, 7);
    tbl[16] = v(0, 0, 0, 0, 1, 32'hFFFFFFFF,     1, 32'hFFFFFFFC, 32'h24, 32'h10000009, 8);
    tbl[17] = v(0, 0, 0, 0, 0, 0,                1, 32'h0, 32'hFFFFFFFC, 32'h4FFFFFFF, 9);
    tbl[18] = v(0, 0, 0, 0, 0, 0,                1, 32'h4, 32'h0, 32'h10000000, 10);
    tbl[19] = v(1, 6'b000011, 1, 32'h80, 1, 32'h90, 0, 0, 0, 0, 0);
    tbl[20] = v(0, 0, 0, 0, 0, 0,                1, 0, 0, 0, 0);
    tbl[21] = v(0, 0, 0, 0, 0, 0,                1, 32'h4, 0, 32'h10000000, 1);
    #1;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].np, tbl[i].b, tbl[i].t);
      cmp($sformatf("vec%0d", i), tbl[i].ce, tbl[i].addr, tbl[i].ipc, tbl[i].iinst, tbl[i].cnt);
    end
    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      s = {$urandom_range(0, 7)} == 0 ? 6'b000111 : ({$urandom_range(0, 4)} == 0 ? 6'b000011 : 6'($urandom_range(0, 63)) & {$urandom_range(0, 3) == 0, 5'b11111});
      step($urandom_range(0, 49) == 0, s, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom);
      cmp($sformatf("rnd%0d", i), m_ce, m_pc, m_id_pc, m_id_inst, m_cnt);
    end
    step(0, 0, 0, 0, 1, 32'h300);
    step(0, 0, 0, 0, 0, 0);
    step(1, 6'b000111, 1, 32'h44, 1, 32'h55);
    cmp("midrst", 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h44, 1, 32'h55);
    cmp("midrst_ce_gap", 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    cmp("midrst_first", 1, 32'h4, 0, 32'h10000000, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
